// File: rtl/fetch_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_seq_ctrl
//
// Purpose:
//   Instruction-fetch sequencer sitting between the PC register and an
//   SRAM-like instruction bus (req / addr_ok / data_ok). It keeps exactly one
//   fetch outstanding, tells the PC when to advance (pc+4 or a redirect
//   target), remembers redirects that arrive while a fetch is in flight so
//   the wrong-path word can be thrown away, and holds one fetched
//   instruction for the decode stage.
//
// Ports:
//   clock_i             clock
//   reset_i             asynchronous reset, active-low
//   pc_i                current PC register value
//   pc_advance_o        PC updates at the next edge (0 holds PC)
//   pc_redirect_o       with pc_advance_o: load pc_redirect_addr_o, not pc+4
//   pc_redirect_addr_o  redirect target for the PC
//   redirect_i          flush/redirect request (already prioritised)
//   redirect_addr_i     target of redirect_i
//   inst_req_o          bus request
//   inst_addr_o         bus address
//   inst_addr_ok_i      bus accepted the request
//   inst_data_ok_i      bus read data valid
//   inst_rdata_i        bus read data
//   id_stall_i          decode cannot accept the buffered entry
//   inst_valid_o        output buffer holds an entry
//   inst_o              buffered instruction word
//   inst_pc_o           PC of the buffered instruction
//   inst_adel_o         buffered entry is a misaligned-fetch fault
//
// Optional feature (define FETCH_PERF_CNT_EN):
//   perf_wait_cycles_o  saturating count of cycles spent in S_REQ or S_WAIT
//   perf_cancel_cnt_o   saturating count of returned words that were dropped
// ---------------------------------------------------------------------------
module fetch_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int PERF_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [31:0]       pc_i,
    output logic              pc_advance_o,
    output logic              pc_redirect_o,
    output logic [31:0]       pc_redirect_addr_o,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_addr_i,
    output logic              inst_req_o,
    output logic [31:0]       inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    input  logic              id_stall_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [31:0]       inst_pc_o,
    output logic              inst_adel_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_wait_cycles_o,
    output logic [PERF_W-1:0] perf_cancel_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                buf_valid_q;
    logic [DATA_W-1:0]   buf_inst_q;
    logic [31:0]         buf_pc_q;
    logic                buf_adel_q;

    logic                cancel_q;
    logic [31:0]         pend_addr_q;

    logic                buf_free;
    logic                buf_consume;
    logic                buf_load;
    logic [DATA_W-1:0]   load_inst;
    logic                load_adel;
    logic                buf_flush;
    logic                set_cancel;
    logic                clr_cancel;

    // The buffer is handed to decode on any cycle it is valid and decode is
    // not stalling; "free" means a new entry could be written this cycle.
    assign buf_consume = buf_valid_q & ~id_stall_i;
    assign buf_free    = ~buf_valid_q | ~id_stall_i;

    assign inst_valid_o = buf_valid_q;
    assign inst_o       = buf_inst_q;
    assign inst_pc_o    = buf_pc_q;
    assign inst_adel_o  = buf_adel_q;

    // Next-state and control decode. Every non-buffer output is a pure
    // function of the current state and inputs. While reset_i is low all of
    // them are forced to 0 so the bus and PC see nothing even if redirect_i
    // happens to be high during reset. A redirect that coincides with the
    // returning word wins over an older pending redirect (newest target).
    always_comb begin
        state_d            = state_q;
        pc_advance_o       = 1'b0;
        pc_redirect_o      = 1'b0;
        pc_redirect_addr_o = 32'd0;
        inst_req_o         = 1'b0;
        inst_addr_o        = 32'd0;
        buf_load           = 1'b0;
        load_inst          = '0;
        load_adel          = 1'b0;
        buf_flush          = 1'b0;
        set_cancel         = 1'b0;
        clr_cancel         = 1'b0;
        if (reset_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (redirect_i) begin
                        pc_advance_o       = 1'b1;
                        pc_redirect_o      = 1'b1;
                        pc_redirect_addr_o = redirect_addr_i;
                        buf_flush          = 1'b1;
                    end else if (buf_free && (pc_i[1:0] != 2'b00)) begin
                        buf_load  = 1'b1;
                        load_adel = 1'b1;
                        state_d   = S_ERR;
                    end else if (buf_free) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    inst_req_o  = 1'b1;
                    inst_addr_o = pc_i;
                    if (redirect_i) begin
                        set_cancel = 1'b1;
                        buf_flush  = 1'b1;
                    end
                    if (inst_addr_ok_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok_i) begin
                        state_d    = S_IDLE;
                        clr_cancel = 1'b1;
                        if (redirect_i) begin
                            pc_advance_o       = 1'b1;
                            pc_redirect_o      = 1'b1;
                            pc_redirect_addr_o = redirect_addr_i;
                            buf_flush          = 1'b1;
                        end else if (cancel_q) begin
                            pc_advance_o       = 1'b1;
                            pc_redirect_o      = 1'b1;
                            pc_redirect_addr_o = pend_addr_q;
                        end else begin
                            pc_advance_o = 1'b1;
                            buf_load     = 1'b1;
                            load_inst    = inst_rdata_i;
                        end
                    end else if (redirect_i) begin
                        set_cancel = 1'b1;
                        buf_flush  = 1'b1;
                    end
                end
                S_ERR: begin
                    if (redirect_i) begin
                        pc_advance_o       = 1'b1;
                        pc_redirect_o      = 1'b1;
                        pc_redirect_addr_o = redirect_addr_i;
                        buf_flush          = 1'b1;
                        state_d            = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, output buffer and pending-redirect registers. Buffer priority
    // is flush, then load, then consume, otherwise hold. The PC captured
    // with a load is pc_i itself, because the PC only advances on the same
    // edge that writes the buffer.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            buf_valid_q <= 1'b0;
            buf_inst_q  <= '0;
            buf_pc_q    <= 32'd0;
            buf_adel_q  <= 1'b0;
            cancel_q    <= 1'b0;
            pend_addr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (buf_flush) begin
                buf_valid_q <= 1'b0;
            end else if (buf_load) begin
                buf_valid_q <= 1'b1;
                buf_inst_q  <= load_inst;
                buf_pc_q    <= pc_i;
                buf_adel_q  <= load_adel;
            end else if (buf_consume) begin
                buf_valid_q <= 1'b0;
            end
            if (clr_cancel) begin
                cancel_q <= 1'b0;
            end else if (set_cancel) begin
                cancel_q    <= 1'b1;
                pend_addr_q <= redirect_addr_i;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic in_flight;
    logic discard;

    assign in_flight = (state_q == S_REQ) || (state_q == S_WAIT);
    assign discard   = reset_i && (state_q == S_WAIT) && inst_data_ok_i &&
                       (cancel_q || redirect_i);

    // Performance counters stick at all ones instead of wrapping.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_wait_cycles_o <= '0;
            perf_cancel_cnt_o  <= '0;
        end else begin
            if (in_flight && (perf_wait_cycles_o != {PERF_W{1'b1}})) begin
                perf_wait_cycles_o <= perf_wait_cycles_o + 1'b1;
            end
            if (discard && (perf_cancel_cnt_o != {PERF_W{1'b1}})) begin
                perf_cancel_cnt_o <= perf_cancel_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_seq_ctrl
//
// Purpose:
//   Self-checking bench for fetch_seq_ctrl. The bench plays the PC register
//   and the instruction bus. Directed stimulus pushes the expected bus
//   requests, PC-advance pulses and buffer entries into queues; a negedge
//   monitor pops and compares them as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_fetch_seq_ctrl;

    logic        clock_i;
    logic        reset_i;
    logic [31:0] pc_i;
    logic        pc_advance_o;
    logic        pc_redirect_o;
    logic [31:0] pc_redirect_addr_o;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        id_stall_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_adel_o;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } exp_inst_t;

    typedef struct packed {
        logic        redir;
        logic [31:0] addr;
    } exp_adv_t;

    logic [31:0] exp_req_q[$];
    exp_inst_t   exp_inst_q[$];
    exp_adv_t    exp_adv_q[$];

    int          check_count;
    int          pass_count;
    logic [31:0] pc_next;
    logic        prev_valid;
    logic        prev_consumed;

    fetch_seq_ctrl #(
        .DATA_W(32),
        .PERF_W(32)
    ) dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .pc_i              (pc_i),
        .pc_advance_o      (pc_advance_o),
        .pc_redirect_o     (pc_redirect_o),
        .pc_redirect_addr_o(pc_redirect_addr_o),
        .redirect_i        (redirect_i),
        .redirect_addr_i   (redirect_addr_i),
        .inst_req_o        (inst_req_o),
        .inst_addr_o       (inst_addr_o),
        .inst_addr_ok_i    (inst_addr_ok_i),
        .inst_data_ok_i    (inst_data_ok_i),
        .inst_rdata_i      (inst_rdata_i),
        .id_stall_i        (id_stall_i),
        .inst_valid_o      (inst_valid_o),
        .inst_o            (inst_o),
        .inst_pc_o         (inst_pc_o),
        .inst_adel_o       (inst_adel_o)
    );

    // Free-running clock, period 10.
    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: sim time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic expReq(input logic [31:0] addr);
        exp_req_q.push_back(addr);
    endtask

    task automatic expInst(input logic [31:0] inst, input logic [31:0] pc, input logic adel);
        exp_inst_t e;
        e.inst = inst;
        e.pc   = pc;
        e.adel = adel;
        exp_inst_q.push_back(e);
    endtask

    task automatic expAdv(input logic redir, input logic [31:0] addr);
        exp_adv_t e;
        e.redir = redir;
        e.addr  = addr;
        exp_adv_q.push_back(e);
    endtask

    // Advance to just after the next rising edge and apply the PC update
    // that the monitor worked out from the previous cycle's advance pulse.
    task automatic tick();
        @(posedge clock_i);
        #1;
        pc_i = pc_next;
    endtask

    // Drive one cycle's worth of inputs and let the combinational outputs
    // settle before the caller looks at them.
    task automatic applyStimulus(input logic redir, input logic [31:0] raddr,
                                 input logic aok, input logic dok,
                                 input logic [31:0] rdata, input logic stall);
        redirect_i      = redir;
        redirect_addr_i = raddr;
        inst_addr_ok_i  = aok;
        inst_data_ok_i  = dok;
        inst_rdata_i    = rdata;
        id_stall_i      = stall;
        #1;
    endtask

    // Assert reset (possibly mid-transaction), check that every output is
    // 0 even with a redirect pending on the inputs, then release it with
    // the PC register loaded to pc.
    task automatic applyReset(input logic [31:0] pc);
        reset_i         = 1'b0;
        redirect_i      = 1'b1;
        redirect_addr_i = 32'hdeadbeec;
        inst_addr_ok_i  = 1'b1;
        inst_data_ok_i  = 1'b1;
        inst_rdata_i    = 32'hffffffff;
        id_stall_i      = 1'b0;
        pc_i            = pc;
        pc_next         = pc;
        #1;
        checkOutput("rst_pc_advance", {63'd0, pc_advance_o}, 64'd0);
        checkOutput("rst_pc_redirect", {63'd0, pc_redirect_o}, 64'd0);
        checkOutput("rst_redirect_addr", {32'd0, pc_redirect_addr_o}, 64'd0);
        checkOutput("rst_req", {63'd0, inst_req_o}, 64'd0);
        checkOutput("rst_addr", {32'd0, inst_addr_o}, 64'd0);
        checkOutput("rst_valid", {63'd0, inst_valid_o}, 64'd0);
        checkOutput("rst_inst", {32'd0, inst_o}, 64'd0);
        checkOutput("rst_inst_pc", {32'd0, inst_pc_o}, 64'd0);
        checkOutput("rst_adel", {63'd0, inst_adel_o}, 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        tick();
        reset_i = 1'b1;
    endtask

    // Scoreboard monitor: at each falling edge pop and compare whatever the
    // DUT produced this cycle, and model the PC register update.
    always @(negedge clock_i) begin
        if (!reset_i) begin
            prev_valid    = 1'b0;
            prev_consumed = 1'b0;
        end else begin
            if (inst_req_o && inst_addr_ok_i) begin
                if (exp_req_q.size() == 0) begin
                    checkOutput("req_unexpected", {32'd0, inst_addr_o}, 64'd0);
                end else begin
                    checkOutput("req_addr", {32'd0, inst_addr_o}, {32'd0, exp_req_q.pop_front()});
                end
            end
            if (pc_advance_o) begin
                if (exp_adv_q.size() == 0) begin
                    checkOutput("adv_unexpected", {63'd0, pc_advance_o}, 64'd0);
                end else begin
                    exp_adv_t ea;
                    ea = exp_adv_q.pop_front();
                    checkOutput("adv_redirect", {63'd0, pc_redirect_o}, {63'd0, ea.redir});
                    if (ea.redir) begin
                        checkOutput("adv_target", {32'd0, pc_redirect_addr_o}, {32'd0, ea.addr});
                    end
                end
                pc_next = pc_redirect_o ? pc_redirect_addr_o : pc_i + 32'd4;
            end else begin
                pc_next = pc_i;
            end
            if (inst_valid_o && (!prev_valid || prev_consumed)) begin
                if (exp_inst_q.size() == 0) begin
                    checkOutput("inst_unexpected", {63'd0, inst_valid_o}, 64'd0);
                end else begin
                    exp_inst_t ei;
                    ei = exp_inst_q.pop_front();
                    checkOutput("buf_inst", {32'd0, inst_o}, {32'd0, ei.inst});
                    checkOutput("buf_pc", {32'd0, inst_pc_o}, {32'd0, ei.pc});
                    checkOutput("buf_adel", {63'd0, inst_adel_o}, {63'd0, ei.adel});
                end
            end
            prev_valid    = inst_valid_o;
            prev_consumed = inst_valid_o && !id_stall_i;
        end
    end

    initial begin
        check_count   = 0;
        pass_count    = 0;
        prev_valid    = 1'b0;
        prev_consumed = 1'b0;
        reset_i       = 1'b0;
        pc_i          = 32'd0;
        pc_next       = 32'd0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();

        // Basic fetch: IDLE -> REQ -> WAIT with data_ok right after addr_ok.
        $display("[TB] basic fetch");
        applyReset(32'hbfc00000);
        expReq(32'hbfc00000);
        expAdv(1'b0, 32'd0);
        expInst(32'h24080001, 32'hbfc00000, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("t1_idle_noreq", {63'd0, inst_req_o}, 64'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("t1_req", {63'd0, inst_req_o}, 64'd1);
        checkOutput("t1_req_noadv", {63'd0, pc_advance_o}, 64'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h24080001, 1'b1);
        checkOutput("t1_wait_noreq", {63'd0, inst_req_o}, 64'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("t1_valid", {63'd0, inst_valid_o}, 64'd1);
        tick();

        // Decode stalls with the buffer full: nothing issues, entry holds.
        $display("[TB] decode stall");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
            checkOutput("t4_stall_noreq", {63'd0, inst_req_o}, 64'd0);
            checkOutput("t4_stall_hold", {32'd0, inst_o}, 64'h24080001);
            tick();
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        expReq(32'hbfc00004);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("t4_req_after_stall", {63'd0, inst_req_o}, 64'd1);
        tick();
        expAdv(1'b0, 32'd0);
        expInst(32'h8c010004, 32'hbfc00004, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h8c010004, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();

        // Redirect while waiting: returned word is dropped, PC redirected.
        $display("[TB] redirect in wait");
        applyReset(32'hbfc00000);
        expReq(32'hbfc00000);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hbfc00380, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("t2_redir_noadv", {63'd0, pc_advance_o}, 64'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        expAdv(1'b1, 32'hbfc00380);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'hdeadbeef, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("t2_discard_novalid", {63'd0, inst_valid_o}, 64'd0);
        tick();
        expReq(32'hbfc00380);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        tick();
        expAdv(1'b0, 32'd0);
        expInst(32'h11111111, 32'hbfc00380, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h11111111, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();

        // Two redirects in flight (one in REQ, one in WAIT): newest wins.
        $display("[TB] double redirect");
        applyReset(32'h80000000);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h80001000, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        expReq(32'h80000000);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h80002000, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        expAdv(1'b1, 32'h80002000);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'hbadbad00, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        expReq(32'h80002000);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        tick();
        expAdv(1'b0, 32'd0);
        expInst(32'h22222222, 32'h80002000, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h22222222, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();

        // Misaligned PC: fault entry, no bus traffic until a redirect.
        $display("[TB] misaligned pc");
        applyReset(32'hbfc00000);
        expAdv(1'b1, 32'hbfc00002);
        applyStimulus(1'b1, 32'hbfc00002, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        expInst(32'd0, 32'hbfc00002, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h55555555, 1'b1);
            checkOutput("t5_err_noreq", {63'd0, inst_req_o}, 64'd0);
            checkOutput("t5_err_adel", {63'd0, inst_adel_o}, 64'd1);
            checkOutput("t5_err_valid", {63'd0, inst_valid_o}, 64'd1);
            tick();
        end
        expAdv(1'b1, 32'hbfc00380);
        applyStimulus(1'b1, 32'hbfc00380, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("t5_flushed", {63'd0, inst_valid_o}, 64'd0);
        tick();
        expReq(32'hbfc00380);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        tick();
        expAdv(1'b0, 32'd0);
        expInst(32'h33333333, 32'hbfc00380, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h33333333, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();

        // Reset in the middle of a cancelled fetch: no stale cancel after.
        $display("[TB] reset mid-wait");
        applyReset(32'hbfc00000);
        expReq(32'hbfc00000);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hbfc00380, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyReset(32'hbfc00000);
        expReq(32'hbfc00000);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        expAdv(1'b0, 32'd0);
        expInst(32'h44444444, 32'hbfc00000, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h44444444, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();

        checkOutput("left_req", 64'(exp_req_q.size()), 64'd0);
        checkOutput("left_adv", 64'(exp_adv_q.size()), 64'd0);
        checkOutput("left_inst", 64'(exp_inst_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
